// File: rtl/pattern_search_pkg.sv
// pattern_search_pkg
// Shared definitions for the pattern search controller:
//   state_e               - controller states (IDLE, SEARCH, FINISH)
//   ADDR_W_DEFAULT        - default address width
//   pattern_search_hash() - location hash, x ^ (x << 1), on a 32-bit word;
//                           callers keep the low ADDR_W bits.
package pattern_search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int ADDR_W_DEFAULT = 9;

  function automatic logic [31:0] pattern_search_hash(input logic [31:0] loc);
    return loc ^ (loc << 1);
  endfunction

endpackage

// File: rtl/pattern_search_hash_reg.sv
// pattern_search_hash_reg
// Registered hash of the current search location. Updated every clock edge.
// Ports:
//   clock      - clock
//   reset      - asynchronous active-low reset (clears the hash to 0)
//   location_i - address currently under compare
//   outcell_o  - registered hash of location_i, truncated to ADDR_W
module pattern_search_hash_reg
  import pattern_search_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] location_i,
  output logic [ADDR_W-1:0] outcell_o
);

  logic [31:0]       hash_full;
  logic [ADDR_W-1:0] outcell_d;
  logic [ADDR_W-1:0] outcell_q;
  logic              unused_hash_hi;

  assign hash_full      = pattern_search_hash(32'(location_i));
  assign outcell_d      = hash_full[ADDR_W-1:0];
  // Bits above ADDR_W are discarded by definition of the hash.
  assign unused_hash_hi = ^hash_full[31:ADDR_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) outcell_q <= '0;
    else        outcell_q <= outcell_d;
  end

  assign outcell_o = outcell_q;

endmodule

// File: rtl/pattern_search_ctrl.sv
// pattern_search_ctrl
// Search controller: on an accepted start, walks addresses from base_addr in
// steps of STEP up to MAX_ADDR, stopping on the first hit, at the window
// limit, or on abort. Reports found/done status and the hit address.
// Optional feature: define PATTERN_SEARCH_HASH_EN to get a registered hash of
// location on outcell; otherwise outcell is tied to 0.
// Ports:
//   clock, reset   - clock, asynchronous active-low reset
//   start          - search request, accepted only in IDLE
//   base_addr      - first address, sampled with an accepted start
//   abort          - cancels an active search (ignored in FINISH)
//   hit            - compare result for the current location (same cycle)
//   location       - registered address under compare (0 in IDLE)
//   inc_flag       - location advances at the next edge
//   busy           - high in SEARCH and FINISH
//   found          - last search hit; cleared by the next accepted start
//   done           - one-cycle completion pulse
//   match_address  - address of the most recent hit
//   outcell        - registered hash of location (or 0)
module pattern_search_ctrl
  import pattern_search_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int MAX_ADDR = 2**ADDR_W - 1,
  parameter int STEP     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  input  logic              hit,
  output logic [ADDR_W-1:0] location,
  output logic              inc_flag,
  output logic              busy,
  output logic              found,
  output logic              done,
  output logic [ADDR_W-1:0] match_address,
  output logic [ADDR_W-1:0] outcell
);

  // Limit arithmetic carries one extra bit so location + STEP never wraps.
  localparam logic [ADDR_W:0] MAX_W  = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [ADDR_W:0] STEP_W = (ADDR_W+1)'(STEP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] location_q, location_d;
  logic [ADDR_W-1:0] match_q, match_d;
  logic              found_q, found_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   next_loc_w;
  logic              limit_reached;

  assign next_loc_w    = {1'b0, location_q} + STEP_W;
  assign limit_reached = next_loc_w > MAX_W;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      location_q <= '0;
      match_q    <= '0;
      found_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      location_q <= location_d;
      match_q    <= match_d;
      found_q    <= found_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    location_d = location_q;
    match_d    = match_q;
    found_d    = found_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        location_d = '0;
        if (start) begin
          location_d = base_addr;
          found_d    = 1'b0;
          // A base beyond the window goes straight to FINISH with no compare.
          state_d    = ({1'b0, base_addr} > MAX_W) ? FINISH : SEARCH;
        end
      end
      SEARCH: begin
        if (abort) begin
          state_d    = IDLE;
          location_d = '0;
        end else if (hit) begin
          match_d = location_q;
          found_d = 1'b1;
          state_d = FINISH;
        end else if (limit_reached) begin
          state_d = FINISH;
        end else begin
          location_d = next_loc_w[ADDR_W-1:0];
        end
      end
      FINISH: begin
        // done is registered, so it pulses in the first IDLE cycle.
        done_d     = 1'b1;
        location_d = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d    = IDLE;
        location_d = '0;
      end
    endcase
  end

  assign location      = location_q;
  assign match_address = match_q;
  assign found         = found_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);
  assign inc_flag      = (state_q == SEARCH) & ~abort & ~hit & ~limit_reached;

`ifdef PATTERN_SEARCH_HASH_EN
  pattern_search_hash_reg #(
    .ADDR_W(ADDR_W)
  ) u_hash_reg (
    .clock     (clock),
    .reset     (reset),
    .location_i(location_q),
    .outcell_o (outcell)
  );
`else
  assign outcell = '0;
`endif

endmodule

// File: tb/tb_pattern_search_ctrl.sv
// tb_pattern_search_ctrl
// Directed bench for pattern_search_ctrl (ADDR_W = 9, MAX_ADDR = 511, STEP = 1).
// Outputs are sampled 1 time unit after the rising edge; inputs are driven
// at the same point.
module tb_pattern_search_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] base_addr;
  logic       abort;
  logic       hit;
  logic [8:0] location;
  logic       inc_flag;
  logic       busy;
  logic       found;
  logic       done;
  logic [8:0] match_address;
  logic [8:0] outcell;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pattern_search_ctrl #(
    .ADDR_W  (9),
    .MAX_ADDR(511),
    .STEP    (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .abort        (abort),
    .hit          (hit),
    .location     (location),
    .inc_flag     (inc_flag),
    .busy         (busy),
    .found        (found),
    .done         (done),
    .match_address(match_address),
    .outcell      (outcell)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue an accepted start from IDLE; returns just after the start edge.
  task automatic do_start(input logic [8:0] b);
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; base_addr = '0; abort = 1'b0; hit = 1'b0;
    #2;
    checks++;
    if ({location, inc_flag, busy, found, done, match_address, outcell} !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs loc=%0h inc=%b busy=%b found=%b done=%b match=%0h outcell=%0h required all 0",
               location, inc_flag, busy, found, done, match_address, outcell);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || location !== 9'd0) begin
      failures++;
      $display("FAIL reset_idle busy=%b loc=%0h required busy=0 loc=0", busy, location);
    end
  endtask

  task automatic test_hit();
    do_start(9'd5);
    checks++;
    if (location !== 9'd5 || busy !== 1'b1 || inc_flag !== 1'b1) begin
      failures++;
      $display("FAIL hit_first loc=%0h busy=%b inc=%b required loc=5 busy=1 inc=1", location, busy, inc_flag);
    end
    tick(); tick(); tick();
    checks++;
    if (location !== 9'd8) begin
      failures++;
      $display("FAIL hit_walk loc=%0h required 8", location);
    end
    hit = 1'b1;
    #1;
    checks++;
    if (inc_flag !== 1'b0) begin
      failures++;
      $display("FAIL hit_incflag inc=%b required 0", inc_flag);
    end
    tick();                 // edge 4: FINISH
    hit   = 1'b0;
    abort = 1'b1;           // ignored in FINISH
    checks++;
    if (found !== 1'b1 || match_address !== 9'd8 || done !== 1'b0 || busy !== 1'b1 || location !== 9'd8) begin
      failures++;
      $display("FAIL hit_finish found=%b match=%0h done=%b busy=%b loc=%0h required found=1 match=8 done=0 busy=1 loc=8",
               found, match_address, done, busy, location);
    end
    tick();                 // edge 5: done pulse
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || found !== 1'b1 || match_address !== 9'd8) begin
      failures++;
      $display("FAIL hit_done done=%b busy=%b found=%b match=%0h required done=1 busy=0 found=1 match=8",
               done, busy, found, match_address);
    end
    tick();
    checks++;
    if (done !== 1'b0 || found !== 1'b1) begin
      failures++;
      $display("FAIL hit_pulse_width done=%b found=%b required done=0 found=1", done, found);
    end
  endtask

  task automatic test_window_limit();
    logic [8:0] exp_loc;
    do_start(9'd508);
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL limit_found_clear found=%b required 0", found);
    end
    for (int i = 0; i < 4; i++) begin
      exp_loc = 9'd508 + 9'(i);
      checks++;
      if (location !== exp_loc || inc_flag !== (i < 3) || done !== 1'b0) begin
        failures++;
        $display("FAIL limit_walk%0d loc=%0h inc=%b done=%b required loc=%0h inc=%b done=0",
                 i, location, inc_flag, done, exp_loc, (i < 3));
      end
      tick();
    end
    checks++;
    if (location !== 9'd511 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL limit_finish loc=%0h busy=%b done=%b required loc=1ff busy=1 done=0", location, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || found !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL limit_done done=%b found=%b busy=%b required done=1 found=0 busy=0", done, found, busy);
    end
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    do_start(9'd0);
    tick(); tick(); tick();
    checks++;
    if (location !== 9'd3) begin
      failures++;
      $display("FAIL abort_walk loc=%0h required 3", location);
    end
    abort = 1'b1;
    #1;
    checks++;
    if (inc_flag !== 1'b0) begin
      failures++;
      $display("FAIL abort_incflag inc=%b required 0", inc_flag);
    end
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || location !== 9'd0 || found !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b loc=%0h found=%b done=%b required 0 0 0 0", busy, location, found, done);
    end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL abort_no_done pulses=%0d required 0", done_seen);
    end
  endtask

  task automatic test_collisions();
    // hit and abort together: abort wins
    do_start(9'd20);
    tick();
    hit = 1'b1; abort = 1'b1;
    tick();
    hit = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || found !== 1'b0 || location !== 9'd0 || match_address !== 9'd8) begin
      failures++;
      $display("FAIL coll_hit_abort busy=%b found=%b loc=%0h match=%0h required busy=0 found=0 loc=0 match=8",
               busy, found, location, match_address);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL coll_no_done done=%b required 0", done);
    end
    // start while busy: ignored
    do_start(9'd30);
    base_addr = 9'd100;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (location !== 9'd31 || busy !== 1'b1) begin
      failures++;
      $display("FAIL coll_start_busy loc=%0h busy=%b required loc=1f busy=1", location, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_hash();
    do_start(9'h0A5);
    checks++;
    if (location !== 9'h0A5) begin
      failures++;
      $display("FAIL hash_loc loc=%0h required a5", location);
    end
    tick();
`ifdef PATTERN_SEARCH_HASH_EN
    checks++;
    if (outcell !== 9'h1EF) begin
      failures++;
      $display("FAIL hash_value outcell=%0h required 1ef", outcell);
    end
`else
    checks++;
    if (outcell !== 9'h000) begin
      failures++;
      $display("FAIL hash_disabled outcell=%0h required 0", outcell);
    end
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_search();
    do_start(9'd0);
    tick(); tick(); tick(); tick();
    checks++;
    if (location !== 9'd4) begin
      failures++;
      $display("FAIL rst_mid_walk loc=%0h required 4", location);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({location, inc_flag, busy, found, done, match_address, outcell} !== 40'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs loc=%0h inc=%b busy=%b found=%b done=%b match=%0h outcell=%0h required all 0",
               location, inc_flag, busy, found, done, match_address, outcell);
    end
    tick();
    reset = 1'b1;
    tick();
    do_start(9'd2);
    checks++;
    if (location !== 9'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_restart loc=%0h busy=%b required loc=2 busy=1", location, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_window_limit();
    test_abort();
    test_collisions();
    test_hash();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
